cdr_tap_step_controller: RTL
============================

Name: cdr_tap_step_controller

Overview:
Bang-bang loop controller for the 16-tap shift-register delay line in the PRN-based CDR. It integrates early/late votes from the phase detector and issues single-cycle shift-left (sl) or shift-right (sr) commands to the delay line tap selector. After each step it enforces a hold-off so the delay line output can settle. It mirrors the delay line's current tap index and reports lock.

Parameters:
THRESH, 8, net vote magnitude that triggers one tap step (2..15)
ACC_W, 5, signed accumulator width; must hold ±THRESH
HOLDOFF, 4, cycles the controller spends in HOLD after a step, pulse cycle included (≥2)
LOCK_WIN, 64, consecutive step-free TRACK cycles required to assert locked
NTAPS, 16, delay line taps; tap index width is 4

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
en  in  1  loop enable
early  in  1  phase detector: data early, so more delay is needed
late  in  1  phase detector: data late, so less delay is needed
sl  out  1  registered one-cycle pulse; delay line moves to tap+1 (15 wraps to 0)
sr  out  1  registered one-cycle pulse; delay line moves to tap-1 (0 wraps to 15)
tap_idx  out  4  mirrored tap index of the delay line
locked  out  1  loop settled
busy  out  1  high while in HOLD

Behaviour:
- Reset is synchronous and active-high on clk. On reset: state IDLE, acc=0, tap_idx=0, sl=sr=0, locked=0, busy=0, hold and lock counters 0. Reset dominates en.
- Vote decode: early=1 and late=0 gives +1. early=0 and late=1 gives -1. Both inputs equal gives 0 (no vote). Votes are sampled only in TRACK.
- States:
  - IDLE: all counters held at 0; sl=sr=0; tap_idx retained. When en=1, go to TRACK at the next edge.
  - TRACK: at each edge, acc <= acc + vote.
    - If acc+vote reaches +THRESH: sl<=1, tap_idx<=tap_idx+1 mod 16, acc<=0, go to HOLD, locked<=0.
    - If acc+vote reaches -THRESH: sr<=1, tap_idx<=tap_idx-1 mod 16, acc<=0, go to HOLD, locked<=0.
    - Otherwise the lock counter increments, saturating at LOCK_WIN. locked<=1 when the counter reaches LOCK_WIN.
  - HOLD: busy=1. The sl/sr pulse is high only in the first HOLD cycle. Votes are ignored and acc stays 0. After HOLDOFF cycles in HOLD, return to TRACK.
- Latency: a vote sampled at edge k that reaches threshold makes sl or sr high from edge k to edge k+1. The next vote is accepted at edge k+HOLDOFF.
- sl and sr are never high in the same cycle. tap_idx changes at the same edge the pulse rises.
- en=0 in any state: go to IDLE at the next edge, clear acc and counters, locked<=0, busy<=0. A pulse already high ends normally, so sl/sr are 0 after that edge. tap_idx is not rolled back. Re-enabling resumes from the held tap_idx.
- The accumulator cannot overflow, because it is cleared on reaching ±THRESH. No saturation logic is needed.
- Wrap-around is fixed: sl at tap 15 gives tap 0; sr at tap 0 gives tap 15. This matches the delay line's own state wrap.

Decomposition:
- Package cdr_ctrl_pkg: state enum (IDLE, TRACK, HOLD), TAP_W=4, vote encoding constants (+1/0/-1).
- Sub-module cdr_vote_acc: signed vote accumulator with clear input and ±THRESH compare outputs.
- Top level: FSM, hold counter, lock counter, tap mirror.

Test Plan:
- Reset, en=1, 8 consecutive early=1/late=0 → sl high exactly one cycle on the 8th vote edge, tap_idx 0→1, busy=1 for 4 cycles; sr stays 0.
- From reset, 8 consecutive late → sr pulse, tap_idx 0→15 (wrap). Then 16 steps of 8 early votes each → tap_idx returns to 15 via 0, with 16 sl pulses.
- Alternating early/late, or early=late=1, for 100 cycles from reset → no pulses, acc stays within ±1, locked rises after 64 TRACK cycles. A subsequent step drops locked.
- Votes held high through HOLD (early=1 continuously) → pulses occur every 4+7=11 cycles after the first (hold-off, then 8 votes counting the re-entry edge), confirming HOLD ignores votes.
- 5 early votes, then en=0 for 2 cycles, then 3 early → no pulse (acc cleared). 8 further early votes → sl pulse.
- rst asserted on the sl pulse cycle → next cycle sl=0, tap_idx=0, state IDLE, locked=0.

Source files
------------

// File: rtl/cdr_ctrl_pkg.sv
// Shared definitions for the CDR tap step controller.
// Contents:
//   TAP_W       - width of the delay line tap index (16 taps)
//   cdr_state_t - controller state: IDLE, TRACK, HOLD
//   VOTE_*      - signed 2-bit vote encodings (+1 / 0 / -1)
//   decode_vote - maps the phase detector early/late pair onto a vote
package cdr_ctrl_pkg;

    localparam int TAP_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } cdr_state_t;

    localparam logic [1:0] VOTE_POS  = 2'b01;
    localparam logic [1:0] VOTE_NONE = 2'b00;
    localparam logic [1:0] VOTE_NEG  = 2'b11;

    // early alone asks for more delay (+1), late alone for less (-1).
    // Equal inputs carry no phase information.
    function automatic logic [1:0] decode_vote(input logic early, input logic late);
        logic [1:0] v;
        v = VOTE_NONE;
        if (early && !late) begin
            v = VOTE_POS;
        end else if (!early && late) begin
            v = VOTE_NEG;
        end
        return v;
    endfunction

endpackage

// File: rtl/cdr_vote_acc.sv
// Signed vote accumulator for the CDR loop.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clr       - force the accumulator to zero at the next edge
//   vote_en   - add vote at the next edge (ignored while clr is high)
//   vote      - 2-bit two's complement vote (+1 / 0 / -1)
//   hit_pos   - acc + vote equals +THRESH (only while vote_en)
//   hit_neg   - acc + vote equals -THRESH (only while vote_en)
// On a hit the accumulator returns to zero, so it never leaves the open
// interval (-THRESH, +THRESH) and needs no saturation.
module cdr_vote_acc #(
    parameter int THRESH = 8,
    parameter int ACC_W  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       vote_en,
    input  logic [1:0] vote,
    output logic       hit_pos,
    output logic       hit_neg
);

    localparam logic signed [ACC_W-1:0] POS_T = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] NEG_T = -POS_T;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] vote_ext;
    logic signed [ACC_W-1:0] sum;

    assign vote_ext = {{(ACC_W-2){vote[1]}}, vote};
    assign sum      = acc_q + vote_ext;
    assign hit_pos  = vote_en && !clr && (sum == POS_T);
    assign hit_neg  = vote_en && !clr && (sum == NEG_T);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_q <= '0;
        end else if (vote_en) begin
            if (hit_pos || hit_neg) begin
                acc_q <= '0;
            end else begin
                acc_q <= sum;
            end
        end
    end

endmodule

// File: rtl/cdr_tap_step_controller.sv
// Bang-bang loop controller for the 16-tap delay line of the PRN CDR.
// Integrates early/late votes, issues one-cycle sl/sr tap steps, then
// holds off for HOLDOFF cycles so the delay line can settle.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   en        - loop enable; low sends the controller to IDLE
//   early     - data early, more delay wanted
//   late      - data late, less delay wanted
//   sl        - one-cycle pulse, delay line moves to tap+1 (wraps)
//   sr        - one-cycle pulse, delay line moves to tap-1 (wraps)
//   tap_idx   - mirror of the delay line tap index
//   locked    - LOCK_WIN consecutive step-free TRACK edges seen
//   busy      - high while in HOLD
//   state_dbg - current controller state (cdr_state_t encoding)
module cdr_tap_step_controller
    import cdr_ctrl_pkg::*;
#(
    parameter int THRESH   = 8,
    parameter int ACC_W    = 5,
    parameter int HOLDOFF  = 4,
    parameter int LOCK_WIN = 64,
    parameter int NTAPS    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             early,
    input  logic             late,
    output logic             sl,
    output logic             sr,
    output logic [TAP_W-1:0] tap_idx,
    output logic             locked,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int HC_W = $clog2(HOLDOFF + 1);
    localparam int LC_W = $clog2(LOCK_WIN + 1);

    cdr_state_t       state;
    logic [HC_W-1:0]  hold_cnt;
    logic [LC_W-1:0]  lock_cnt;
    logic             hold_last;
    logic             do_track;
    logic             hit_pos;
    logic             hit_neg;
    logic [TAP_W-1:0] tap_inc;
    logic [TAP_W-1:0] tap_dec;

    // The edge that leaves HOLD is also a vote edge, so the first vote after
    // a step is accepted HOLDOFF edges after the pulse edge.
    assign hold_last = (state == HOLD) && (hold_cnt == HC_W'(HOLDOFF - 1));
    assign do_track  = (state == TRACK) || hold_last;

    assign tap_inc = (tap_idx == TAP_W'(NTAPS - 1)) ? '0 : tap_idx + TAP_W'(1);
    assign tap_dec = (tap_idx == '0) ? TAP_W'(NTAPS - 1) : tap_idx - TAP_W'(1);

    assign state_dbg = state;

    cdr_vote_acc #(
        .THRESH (THRESH),
        .ACC_W  (ACC_W)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clr     (!en || !do_track),
        .vote_en (en && do_track),
        .vote    (decode_vote(early, late)),
        .hit_pos (hit_pos),
        .hit_neg (hit_neg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tap_idx  <= '0;
            sl       <= 1'b0;
            sr       <= 1'b0;
            locked   <= 1'b0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            lock_cnt <= '0;
        end else begin
            // Pulses are one cycle wide; any pulse ends at the next edge.
            sl <= 1'b0;
            sr <= 1'b0;
            if (!en) begin
                state    <= IDLE;
                locked   <= 1'b0;
                busy     <= 1'b0;
                hold_cnt <= '0;
                lock_cnt <= '0;
            end else if (state == IDLE) begin
                state <= TRACK;
            end else if (do_track) begin
                hold_cnt <= '0;
                if (hit_pos || hit_neg) begin
                    sl       <= hit_pos;
                    sr       <= hit_neg;
                    tap_idx  <= hit_pos ? tap_inc : tap_dec;
                    state    <= HOLD;
                    busy     <= 1'b1;
                    locked   <= 1'b0;
                    lock_cnt <= '0;
                end else begin
                    state <= TRACK;
                    busy  <= 1'b0;
                    if (lock_cnt < LC_W'(LOCK_WIN)) begin
                        lock_cnt <= lock_cnt + LC_W'(1);
                    end
                    if (lock_cnt >= LC_W'(LOCK_WIN - 1)) begin
                        locked <= 1'b1;
                    end
                end
            end else begin
                // HOLD, not yet the last cycle
                hold_cnt <= hold_cnt + HC_W'(1);
            end
        end
    end

endmodule
